// File: rtl/snn_run_sequencer.sv
// Purpose: plays a host-loaded event memory into a step-gated snn_core, queues spikes, optional STDP scan and weight dump.
// Latency: 3 cycles per step (FETCH/APPLY/CAPTURE), plus F*N+1 when learning is enabled.
// Backpressure: spike FIFO full stalls FETCH; weight dump holds w_valid/w_data/w_addr until w_ready.
module snn_run_sequencer #(
    parameter int F          = 48,
    parameter int N          = 96,
    parameter int T_MAX      = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(F*N),
    parameter int TW         = $clog2(T_MAX)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [TW:0]   num_steps,
    input  logic          learn_en,
    input  logic          dump_en,
    input  logic          ev_wr_en,
    input  logic [TW-1:0] ev_wr_addr,
    input  logic [F-1:0]  ev_wr_data,
    output logic          busy,
    output logic          done,
    output logic          core_step,
    output logic [F-1:0]  core_event_vec,
    input  logic [N-1:0]  core_spikes_vec,
    output logic          core_stdp_enable,
    output logic [F-1:0]  core_stdp_pre_bits,
    output logic [N-1:0]  core_stdp_post_bits,
    output logic [AW-1:0] core_rb_addr,
    input  logic [15:0]   core_rb_data,
    output logic          spk_valid,
    input  logic          spk_ready,
    output logic [N-1:0]  spk_data,
    output logic [TW-1:0] spk_step,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [15:0]   w_data,
    output logic [AW-1:0] w_addr
);

    localparam int FN = F * N;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_CAPTURE,
        S_LEARN,
        S_GAP,
        S_DRAIN,
        S_DUMP_ADDR,
        S_DUMP_OUT,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] step_q, step_d;
    logic [TW:0]   ns_q, ns_d;
    logic          learn_q, learn_d;
    logic          dump_q, dump_d;
    logic [AW-1:0] lcnt_q, lcnt_d;
    logic [AW-1:0] k_q, k_d;
    logic [F-1:0]  pre_q, pre_d;
    logic [N-1:0]  post_q, post_d;
    logic [F-1:0]  mem_rd_q;

    logic [F-1:0]     ev_mem [T_MAX];
    logic [TW+N-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             fifo_push, fifo_pop;
    logic [TW+N-1:0]  fifo_head;

    logic [TW:0]   ns_clamped;
    logic [TW:0]   step_inc;
    logic          last_step;

    // Host writes land only while idle; contents survive reset so a run can be replayed.
    always_ff @(posedge clk) begin
        if (ev_wr_en && state_q == S_IDLE) begin
            ev_mem[ev_wr_addr] <= ev_wr_data;
        end
    end

    // Registered event read; FETCH re-reads the same address while stalled, so APPLY always sees fresh data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_rd_q <= '0;
        end else if (state_q == S_FETCH) begin
            mem_rd_q <= ev_mem[step_q];
        end
    end

    assign ns_clamped = (num_steps > (TW+1)'(T_MAX)) ? (TW+1)'(T_MAX) : num_steps;
    assign step_inc   = {1'b0, step_q} + (TW+1)'(1);
    assign last_step  = (step_inc == ns_q);

    // Sequencer state and run context registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            ns_q    <= '0;
            learn_q <= 1'b0;
            dump_q  <= 1'b0;
            lcnt_q  <= '0;
            k_q     <= '0;
            pre_q   <= '0;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ns_q    <= ns_d;
            learn_q <= learn_d;
            dump_q  <= dump_d;
            lcnt_q  <= lcnt_d;
            k_q     <= k_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
        end
    end

    // Next-state logic: step loop, optional STDP scan, drain, optional weight dump.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ns_d      = ns_q;
        learn_d   = learn_q;
        dump_d    = dump_q;
        lcnt_d    = lcnt_q;
        k_d       = k_q;
        pre_d     = pre_q;
        post_d    = post_q;
        fifo_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ns_d    = ns_clamped;
                    learn_d = learn_en;
                    dump_d  = dump_en;
                    step_d  = '0;
                    k_d     = '0;
                    state_d = (ns_clamped == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                // A free FIFO slot here guarantees the CAPTURE push two cycles later.
                if (cnt_q < (PW+1)'(FIFO_DEPTH)) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                fifo_push = 1'b1;
                if (learn_q) begin
                    pre_d   = mem_rd_q;
                    post_d  = core_spikes_vec;
                    lcnt_d  = '0;
                    state_d = S_LEARN;
                end else if (last_step) begin
                    state_d = S_DRAIN;
                end else begin
                    step_d  = step_q + TW'(1);
                    state_d = S_FETCH;
                end
            end
            S_LEARN: begin
                if (lcnt_q == AW'(FN - 1)) begin
                    state_d = S_GAP;
                end else begin
                    lcnt_d = lcnt_q + AW'(1);
                end
            end
            S_GAP: begin
                if (last_step) begin
                    state_d = S_DRAIN;
                end else begin
                    step_d  = step_q + TW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = dump_q ? S_DUMP_ADDR : S_FIN;
                end
            end
            S_DUMP_ADDR: begin
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (w_ready) begin
                    if (k_q == AW'(FN - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = S_DUMP_ADDR;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fifo_pop  = spk_valid && spk_ready;
    assign cnt_d     = cnt_q + (PW+1)'(fifo_push) - (PW+1)'(fifo_pop);
    assign fifo_head = fifo_mem[rd_ptr_q];

    // Spike FIFO payload storage; pushes only happen in CAPTURE, never during reset.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= {step_q, core_spikes_vec};
        end
    end

    // Spike FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign spk_valid = (cnt_q != '0);
    assign spk_data  = spk_valid ? fifo_head[N-1:0] : '0;
    assign spk_step  = spk_valid ? fifo_head[TW+N-1:N] : '0;

    assign busy             = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done             = (state_q == S_FIN);
    assign core_step        = (state_q == S_APPLY);
    assign core_event_vec   = (state_q == S_APPLY) ? mem_rd_q : '0;
    assign core_stdp_enable = (state_q == S_LEARN);
    assign core_stdp_pre_bits  = pre_q;
    assign core_stdp_post_bits = post_q;

    // The address is held through DUMP_ADDR and DUMP_OUT; the core registers its read port,
    // so core_rb_data is a registered value that stays stable while waiting on w_ready.
    assign core_rb_addr = k_q;
    assign w_valid      = (state_q == S_DUMP_OUT);
    assign w_data       = (state_q == S_DUMP_OUT) ? core_rb_data : '0;
    assign w_addr       = (state_q == S_DUMP_OUT) ? k_q : '0;

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Purpose: directed bench for snn_run_sequencer with a small behavioural core model.
// Latency: checks step spacing, STDP run length, dump ordering and done timing.
// Backpressure: exercises spike FIFO stall and toggling weight consumer ready.
module tb_snn_run_sequencer;

    localparam int F  = 48;
    localparam int N  = 96;
    localparam int TW = 10;
    localparam int AW = 13;
    localparam int FN = F * N;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [TW:0]   num_steps;
    logic          learn_en;
    logic          dump_en;
    logic          ev_wr_en;
    logic [TW-1:0] ev_wr_addr;
    logic [F-1:0]  ev_wr_data;
    logic          busy;
    logic          done;
    logic          core_step;
    logic [F-1:0]  core_event_vec;
    logic [N-1:0]  core_spikes_vec = '0;
    logic          core_stdp_enable;
    logic [F-1:0]  core_stdp_pre_bits;
    logic [N-1:0]  core_stdp_post_bits;
    logic [AW-1:0] core_rb_addr;
    logic [15:0]   core_rb_data = '0;
    logic          spk_valid;
    logic          spk_ready;
    logic [N-1:0]  spk_data;
    logic [TW-1:0] spk_step;
    logic          w_valid;
    logic          w_ready = 1'b0;
    logic [15:0]   w_data;
    logic [AW-1:0] w_addr;

    snn_run_sequencer dut (
        .clk                 (clk),
        .rstn                (rstn),
        .start               (start),
        .num_steps           (num_steps),
        .learn_en            (learn_en),
        .dump_en             (dump_en),
        .ev_wr_en            (ev_wr_en),
        .ev_wr_addr          (ev_wr_addr),
        .ev_wr_data          (ev_wr_data),
        .busy                (busy),
        .done                (done),
        .core_step           (core_step),
        .core_event_vec      (core_event_vec),
        .core_spikes_vec     (core_spikes_vec),
        .core_stdp_enable    (core_stdp_enable),
        .core_stdp_pre_bits  (core_stdp_pre_bits),
        .core_stdp_post_bits (core_stdp_post_bits),
        .core_rb_addr        (core_rb_addr),
        .core_rb_data        (core_rb_data),
        .spk_valid           (spk_valid),
        .spk_ready           (spk_ready),
        .spk_data            (spk_data),
        .spk_step            (spk_step),
        .w_valid             (w_valid),
        .w_ready             (w_ready),
        .w_data              (w_data),
        .w_addr              (w_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [F-1:0] onehot(input int i);
        return F'(1) << i;
    endfunction

    function automatic logic [15:0] wfn(input logic [AW-1:0] a);
        return (16'(a) * 16'd3) ^ 16'hA5C3;
    endfunction

    // Behavioural core: spikes mirror the applied event twice, readback is registered.
    always @(posedge clk) begin
        if (core_step) core_spikes_vec <= {core_event_vec, core_event_vec};
        core_rb_data <= wfn(core_rb_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic wtog = 1'b0;
    // Weight consumer ready toggles every cycle when enabled, changed just after the edge.
    always @(posedge clk) begin
        #1;
        w_ready = wtog ? ~w_ready : 1'b0;
    end

    int           stp_cyc[$];
    logic [TW-1:0] spk_s[$];
    logic [N-1:0] spk_d[$];
    int           runs[$];
    int           run_end[$];
    logic [F-1:0] pre_l[$];
    logic [N-1:0] post_l[$];
    logic [AW-1:0] wa[$];
    logic [15:0]  wd[$];
    int run_len = 0, done_cnt = 0, done_cyc = 0, last_w_cyc = 0;
    int w_unstable = 0, spk_unstable = 0;
    logic prev_wv = 0, prev_wr = 0, prev_sv = 0, prev_sr = 0;
    logic [AW-1:0] prev_wa = '0;
    logic [15:0] prev_wd = '0;
    logic [N-1:0] prev_sd = '0;
    logic [TW-1:0] prev_ss = '0;

    // Monitor samples on the falling edge, away from DUT updates and stimulus changes.
    always @(negedge clk) begin
        if (rstn) begin
            if (core_step) stp_cyc.push_back(cyc);
            if (spk_valid && spk_ready) begin
                spk_s.push_back(spk_step);
                spk_d.push_back(spk_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (core_stdp_enable) begin
                run_len++;
                if (run_len == 1) begin
                    pre_l.push_back(core_stdp_pre_bits);
                    post_l.push_back(core_stdp_post_bits);
                end
            end else if (run_len != 0) begin
                runs.push_back(run_len);
                run_end.push_back(cyc - 1);
                run_len = 0;
            end
            if (w_valid && w_ready) begin
                wa.push_back(w_addr);
                wd.push_back(w_data);
                last_w_cyc = cyc;
            end
            if (prev_wv && !prev_wr && (!w_valid || w_addr != prev_wa || w_data != prev_wd)) w_unstable++;
            if (prev_sv && !prev_sr && (!spk_valid || spk_data != prev_sd || spk_step != prev_ss)) spk_unstable++;
            prev_wv = w_valid; prev_wr = w_ready; prev_wa = w_addr; prev_wd = w_data;
            prev_sv = spk_valid; prev_sr = spk_ready; prev_sd = spk_data; prev_ss = spk_step;
        end else begin
            run_len = 0;
            prev_wv = 0;
            prev_sv = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev_write(input int addr, input logic [F-1:0] data);
        ev_wr_en   = 1'b1;
        ev_wr_addr = TW'(addr);
        ev_wr_data = data;
        tick();
        ev_wr_en   = 1'b0;
    endtask

    task automatic go(input int ns, input logic le, input logic de);
        num_steps = (TW+1)'(ns);
        learn_en  = le;
        dump_en   = de;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == c0; i++) tick();
        check(tag, 128'(done_cnt - c0), 128'd1);
    endtask

    task automatic clear_logs();
        stp_cyc.delete(); spk_s.delete(); spk_d.delete();
        runs.delete(); run_end.delete(); pre_l.delete(); post_l.delete();
        wa.delete(); wd.delete();
    endtask

    task automatic check_spikes(input string tag, input int n);
        check({tag, "_nspk"}, 128'(spk_s.size()), 128'(n));
        for (int i = 0; i < n && i < spk_s.size(); i++) begin
            check($sformatf("%s_step%0d", tag, i), 128'(spk_s[i]), 128'(i));
            check($sformatf("%s_data%0d", tag, i), 128'(spk_d[i]), 128'({onehot(i), onehot(i)}));
        end
    endtask

    initial begin
        int bad;
        int d0;
        rstn = 1'b0; start = 1'b0; num_steps = '0; learn_en = 1'b0; dump_en = 1'b0;
        ev_wr_en = 1'b0; ev_wr_addr = '0; ev_wr_data = '0; spk_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_spk_valid", 128'(spk_valid), 128'd0);
        check("rst_w_valid", 128'(w_valid), 128'd0);
        check("rst_core_step", 128'(core_step), 128'd0);
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) ev_write(i, onehot(i));

        // Basic run, no backpressure; a write attempted while busy must be dropped.
        clear_logs();
        spk_ready = 1'b1;
        go(4, 1'b0, 1'b0);
        ev_write(0, '1);
        wait_done(100, "t1_done");
        check_spikes("t1", 4);
        check("t1_nsteps", 128'(stp_cyc.size()), 128'd4);
        for (int i = 1; i < 4 && i < stp_cyc.size(); i++)
            check($sformatf("t1_spacing%0d", i), 128'(stp_cyc[i] - stp_cyc[i-1]), 128'd3);
        repeat (3) tick();
        check("t1_busy_after", 128'(busy), 128'd0);

        // Spike consumer stalled: FETCH must stop after four captures.
        clear_logs();
        spk_ready = 1'b0;
        go(6, 1'b0, 1'b0);
        repeat (40) tick();
        check("t2_stalled_steps", 128'(stp_cyc.size()), 128'd4);
        check("t2_head_valid", 128'(spk_valid), 128'd1);
        check("t2_head_step", 128'(spk_step), 128'd0);
        check("t2_busy", 128'(busy), 128'd1);
        spk_ready = 1'b1;
        wait_done(200, "t2_done");
        check_spikes("t2", 6);
        check("t2_spk_stable", 128'(spk_unstable), 128'd0);

        // Learning: F*N-cycle STDP runs with one gap cycle, latched pre/post bits.
        clear_logs();
        go(2, 1'b1, 1'b0);
        wait_done(12000, "t3_done");
        check("t3_nruns", 128'(runs.size()), 128'd2);
        for (int i = 0; i < 2 && i < runs.size(); i++) begin
            check($sformatf("t3_runlen%0d", i), 128'(runs[i]), 128'(FN));
            check($sformatf("t3_pre%0d", i), 128'(pre_l[i]), 128'(onehot(i)));
            check($sformatf("t3_post%0d", i), 128'(post_l[i]), 128'({onehot(i), onehot(i)}));
        end
        if (stp_cyc.size() >= 2 && run_end.size() >= 1) begin
            check("t3_step_spacing", 128'(stp_cyc[1] - stp_cyc[0]), 128'(3 + FN + 1));
            check("t3_gap_to_step", 128'(stp_cyc[1] - run_end[0]), 128'd3);
        end
        check_spikes("t3", 2);

        // Weight dump with toggling consumer ready.
        clear_logs();
        wtog = 1'b1;
        go(1, 1'b0, 1'b1);
        wait_done(30000, "t4_done");
        wtog = 1'b0;
        check("t4_nweights", 128'(wa.size()), 128'(FN));
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != AW'(i) || wd[i] != wfn(AW'(i))) bad++;
        check("t4_order_data", 128'(bad), 128'd0);
        check("t4_w_stable", 128'(w_unstable), 128'd0);
        check("t4_done_after_last", 128'(done_cyc - last_w_cyc), 128'd1);

        // Zero-step run: done on the third cycle counting the start cycle; a second start is ignored.
        clear_logs();
        d0 = done_cnt;
        num_steps = '0; learn_en = 1'b0; dump_en = 1'b0;
        start = 1'b1;
        tick();
        check("t5_busy", 128'(busy), 128'd1);
        tick();
        start = 1'b0;
        check("t5_done", 128'(done), 128'd1);
        check("t5_busy_fin", 128'(busy), 128'd0);
        repeat (5) tick();
        check("t5_done_once", 128'(done_cnt - d0), 128'd1);
        check("t5_no_step", 128'(stp_cyc.size()), 128'd0);
        check("t5_idle", 128'(busy), 128'd0);

        // Reset in the middle of LEARN, then a normal run from the preserved memory.
        clear_logs();
        go(2, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !core_stdp_enable; i++) tick();
        check("t6_in_learn", 128'(core_stdp_enable), 128'd1);
        repeat (100) tick();
        d0 = done_cnt;
        rstn = 1'b0;
        #1;
        check("t6_rst_stdp", 128'(core_stdp_enable), 128'd0);
        check("t6_rst_busy", 128'(busy), 128'd0);
        check("t6_rst_pre", 128'(core_stdp_pre_bits), 128'd0);
        check("t6_rst_post", 128'(core_stdp_post_bits), 128'd0);
        check("t6_rst_spk_valid", 128'(spk_valid), 128'd0);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("t6_no_done", 128'(done_cnt - d0), 128'd0);
        clear_logs();
        go(3, 1'b0, 1'b0);
        wait_done(100, "t6_done");
        check_spikes("t6", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snn_run_sequencer.md
Name: snn_run_sequencer

Overview:
- Hardware replacement for the software-driven step loop around snn_core.
- Holds an event-vector memory loaded by the host and plays T steps into a step-gated snn_core.
- Captures each step's spike vector into a valid/ready output FIFO.
- Optionally runs one full-array STDP scan per step, then streams the learned weights out through the core readback port.

Parameters:
- F, 48, input feature count (event vector width)
- N, 96, neuron count (spike vector width)
- T_MAX, 1024, event memory depth (max steps per run)
- FIFO_DEPTH, 4, spike output FIFO entries (power of 2, >=2)
- AW, $clog2(F*N), weight address width (derived)
- TW, $clog2(T_MAX), step index width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  run request, accepted only in IDLE
- num_steps  in  TW+1  step count, sampled on start; values above T_MAX are clamped to T_MAX
- learn_en  in  1  per-step STDP scan enable, sampled on start
- dump_en  in  1  weight dump after run, sampled on start
- ev_wr_en  in  1  event memory write strobe; honoured only in IDLE
- ev_wr_addr  in  TW  event memory write address
- ev_wr_data  in  F  event vector to write
- busy  out  1  high from start acceptance to done
- done  out  1  one-cycle pulse at run completion
- core_step  out  1  core integrate strobe
- core_event_vec  out  F  event vector for the current step
- core_spikes_vec  in  N  core spike output, valid one cycle after core_step
- core_stdp_enable  out  1  STDP scan enable
- core_stdp_pre_bits  out  F  latched pre bits for the scan
- core_stdp_post_bits  out  N  latched post bits for the scan
- core_rb_addr  out  AW  weight readback address
- core_rb_data  in  16  signed readback data, one-cycle read latency
- spk_valid  out  1  spike FIFO head valid
- spk_ready  in  1  spike consumer ready
- spk_data  out  N  spike vector at FIFO head
- spk_step  out  TW  step index of the FIFO head
- w_valid  out  1  dumped weight valid
- w_ready  in  1  weight consumer ready
- w_data  out  16  dumped weight
- w_addr  out  AW  address of w_data

Behaviour:
- Reset (async, rstn=0): state IDLE, FIFO flushed, step counter 0, all outputs 0. Event memory contents are not cleared. Reset mid-run aborts the run without a done pulse.
- States: IDLE, FETCH, APPLY, CAPTURE, LEARN, GAP, DRAIN, DUMP_ADDR, DUMP_OUT, FIN.
- IDLE:
  - On start: latch num_steps, learn_en and dump_en; set busy=1; step=0.
  - Go to FETCH, or to DRAIN if num_steps==0.
- FETCH: synchronous event memory read of address step. Data is registered the next cycle. Advance to APPLY only when FIFO occupancy < FIFO_DEPTH; otherwise hold.
- APPLY (1 cycle): core_step=1, core_event_vec=mem data. core_event_vec is 0 in every other state.
- CAPTURE (1 cycle):
  - Push {step, core_spikes_vec} into the FIFO; the push is guaranteed to succeed.
  - If learn_en, latch pre/post bits and go to LEARN.
  - Otherwise, if step+1==num_steps go to DRAIN; else step++ and go to FETCH.
- LEARN: core_stdp_enable=1 for exactly F*N consecutive cycles (counter 0..F*N-1), then GAP.
- GAP (1 cycle): core_stdp_enable=0. Then apply the same step/DRAIN decision as CAPTURE.
- DRAIN: wait until the FIFO is empty, then go to DUMP_ADDR if dump_en, else FIN.
- DUMP_ADDR: drive core_rb_addr=k (k starts at 0) for one cycle, then DUMP_OUT.
- DUMP_OUT:
  - w_valid=1, w_data=registered core_rb_data, w_addr=k; hold all three stable until w_ready.
  - On handshake: if k==F*N-1 go to FIN; else k++ and go to DUMP_ADDR.
- FIN: done=1 for one cycle, busy=0; return to IDLE.
- FIFO:
  - Push and pop in the same cycle are both allowed.
  - spk_data and spk_step are stable while spk_valid=1 and spk_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- start while busy is ignored. ev_wr_en while busy is ignored (no write).
- Per-step latency with no backpressure and learning off: 3 cycles. With learning on: 3+F*N+1 cycles.

Test Plan:
- Load 4 events (one-hot bit i at step i), num_steps=4, learn_en=0, spk_ready=1 -> four spk transfers with spk_step 0..3. core_step pulses spaced 3 cycles apart. done pulses once; busy is low afterwards.
- Same run with spk_ready=0 -> after FIFO_DEPTH captures, FETCH stalls and no extra core_step occurs. Raising spk_ready completes all steps in order.
- learn_en=1, num_steps=2 -> core_stdp_enable high for exactly 4608 cycles per step with 1 low gap cycle. pre/post bits equal the applied event and the captured spikes.
- dump_en=1 with w_ready toggled every other cycle -> exactly 4608 weights emitted, w_addr 0..4607 in order, each matching core readback. done follows the last handshake.
- num_steps=0 with dump_en=0 -> no core_step; done occurs 3 cycles after start. A second start issued while busy is ignored.
- rstn asserted mid-LEARN -> all outputs 0 immediately and no done pulse. After rstn is released, a new start runs normally using the preserved event memory.
